// File: rtl/combo_entry_controller_if.sv
// ----------------------------------------------------------------------------
// combo_entry_controller_if
//
// Bundle of every keypad, button and lock-FSM signal that the code-entry
// controller exchanges with its surroundings.
//
// Modports
//   master : the environment (keypad, buttons, lock FSM). It drives the inputs
//            and observes the strobes.
//   slave  : the combo_entry_controller itself.
//
// Signals
//   Key_Valid / Key_Data / Key_Ready : keypad digit handshake
//   Enter_Btn / Change_Btn / Clear   : user buttons (single-cycle pulses)
//   New / Alarm                      : status from the lock FSM
//   Enter_Out / Change_Out           : strobes to the lock FSM
//   isCorrect / Load_Done            : compare result / combination reloaded
//   Digit_Count                      : digits currently buffered
// ----------------------------------------------------------------------------
interface combo_entry_controller_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic               Key_Valid;
    logic [DIGIT_W-1:0] Key_Data;
    logic               Key_Ready;
    logic               Enter_Btn;
    logic               Change_Btn;
    logic               Clear;
    logic               New;
    logic               Alarm;
    logic               Enter_Out;
    logic               Change_Out;
    logic               isCorrect;
    logic               Load_Done;
    logic [CNT_W-1:0]   Digit_Count;

    modport master (
        output Key_Valid, Key_Data, Enter_Btn, Change_Btn, Clear, New, Alarm,
        input  Key_Ready, Enter_Out, Change_Out, isCorrect, Load_Done, Digit_Count
    );

    modport slave (
        input  Key_Valid, Key_Data, Enter_Btn, Change_Btn, Clear, New, Alarm,
        output Key_Ready, Enter_Out, Change_Out, isCorrect, Load_Done, Digit_Count
    );
endinterface

// File: rtl/combo_entry_controller.sv
// ----------------------------------------------------------------------------
// combo_entry_controller
//
// Collects a DIGITS-long code from the keypad, compares it with the stored
// combination when Enter or Change is pressed, and gives the lock FSM a
// one-cycle Enter_Out/Change_Out strobe together with isCorrect. While the
// lock FSM reports New, a full code entered becomes the new combination at
// the end of the evaluation cycle (Load_Done marks it).
//
// Ports
//   Clock  : system clock
//   Resetn : asynchronous, active-low reset
//   bus    : combo_entry_controller_if.slave (handshake, buttons, strobes)
// ----------------------------------------------------------------------------
module combo_entry_controller #(
    parameter int                          DIGITS       = 4,
    parameter int                          DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                          TIMEOUT      = 1000
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    combo_entry_controller_if.slave   bus
);
    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam bit               TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DIGITS);
    localparam logic [TMR_W-1:0] TMR_MAX    = '1;
    // With the timeout disabled the limit is never consulted.
    localparam logic [TMR_W-1:0] TMR_LIMIT  = TIMEOUT_EN ? TMR_W'(TIMEOUT) : '1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CODE_W-1:0]  buffer_q,  buffer_d;
    logic [CODE_W-1:0]  stored_q,  stored_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic               enter_q,   enter_d;
    logic               change_q,  change_d;
    logic               correct_q, correct_d;
    logic               load_q,    load_d;

    logic               key_ready;
    logic               accept;
    logic               button;
    logic [CODE_W-1:0]  buffer_shift;
    logic [TMR_W-1:0]   timer_inc;

    always_comb begin
        key_ready    = (state_q == COLLECT) && (count_q < CNT_FULL) && !bus.Alarm;
        accept       = bus.Key_Valid && key_ready;
        button       = bus.Enter_Btn || bus.Change_Btn;
        // First digit keyed ends up in the most significant position.
        buffer_shift = (buffer_q << DIGIT_W) | {{(CODE_W-DIGIT_W){1'b0}}, bus.Key_Data};
        timer_inc    = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;

        state_d   = state_q;
        buffer_d  = buffer_q;
        stored_d  = stored_q;
        count_d   = count_q;
        timer_d   = timer_q;
        // Strobes and compare result exist only for the single EVAL cycle.
        enter_d   = 1'b0;
        change_d  = 1'b0;
        correct_d = 1'b0;
        load_d    = 1'b0;

        case (state_q)
            COLLECT: begin
                if (bus.Alarm) begin
                    state_d  = LOCKED;
                    buffer_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end else if (bus.Clear) begin
                    // Clear overrides a same-cycle digit and button.
                    buffer_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end else begin
                    if (accept) begin
                        buffer_d = buffer_shift;
                        count_d  = count_q + 1'b1;
                        timer_d  = '0;
                    end
                    if (button) begin
                        // Evaluation sees the digit accepted in this same
                        // cycle, and a pending timeout does not pre-empt a
                        // press: the EVAL cycle discards the buffer anyway.
                        state_d   = EVAL;
                        enter_d   = bus.Enter_Btn;
                        change_d  = !bus.Enter_Btn && bus.Change_Btn;
                        correct_d = !bus.New && (count_d == CNT_FULL) &&
                                    (buffer_d == stored_q);
                        load_d    = bus.New && (count_d == CNT_FULL);
                    end else if (TIMEOUT_EN && !accept && (count_q != '0)) begin
                        // timer_q counts idle cycles already elapsed; this
                        // cycle is one more, so expire when it reaches TIMEOUT.
                        if (timer_inc >= TMR_LIMIT) begin
                            buffer_d = '0;
                            count_d  = '0;
                            timer_d  = '0;
                        end else begin
                            timer_d = timer_inc;
                        end
                    end
                end
            end

            EVAL: begin
                // The new combination is committed at the end of EVAL, so a
                // reset during this cycle leaves the old one in place.
                if (load_q) begin
                    stored_d = buffer_q;
                end
                buffer_d = '0;
                count_d  = '0;
                timer_d  = '0;
                state_d  = bus.Alarm ? LOCKED : COLLECT;
            end

            LOCKED: begin
                state_d = LOCKED;
            end

            default: begin
                state_d  = COLLECT;
                buffer_d = '0;
                count_d  = '0;
                timer_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= COLLECT;
            buffer_q  <= '0;
            stored_q  <= DEFAULT_CODE;
            count_q   <= '0;
            timer_q   <= '0;
            enter_q   <= 1'b0;
            change_q  <= 1'b0;
            correct_q <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buffer_q  <= buffer_d;
            stored_q  <= stored_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            enter_q   <= enter_d;
            change_q  <= change_d;
            correct_q <= correct_d;
            load_q    <= load_d;
        end
    end

    assign bus.Key_Ready   = key_ready;
    assign bus.Enter_Out   = enter_q;
    assign bus.Change_Out  = change_q;
    assign bus.isCorrect   = correct_q;
    assign bus.Load_Done   = load_q;
    assign bus.Digit_Count = count_q;
endmodule

// File: tb/tb_combo_entry_controller.sv
// ----------------------------------------------------------------------------
// tb_combo_entry_controller
//
// Directed scenarios with literal expectations, then randomized keypad and
// button traffic. A queue-based model of the entry rules predicts the outputs;
// a compare process checks the DUT against it every cycle.
// ----------------------------------------------------------------------------
module tb_combo_entry_controller;
    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int TIMEOUT = 8;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    combo_entry_controller_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus ();

    combo_entry_controller #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .DEFAULT_CODE(16'h1234),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];          // digits typed so far, first digit at index 0
    int m_stored;
    int m_idle;
    bit m_eval, m_locked;
    bit m_enter, m_change, m_correct, m_load;

    function automatic int code_of();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stored = 'h1234;
        m_idle = 0;
        m_eval = 0; m_locked = 0;
        m_enter = 0; m_change = 0; m_correct = 0; m_load = 0;
    endtask

    // One clock edge of the entry rules, using the inputs present at the edge.
    task automatic model_step();
        bit took;
        bit old_load;
        old_load = m_load;
        m_enter = 0; m_change = 0; m_correct = 0; m_load = 0;
        if (m_locked) begin
            // nothing leaves lockout except reset
        end else if (m_eval) begin
            if (old_load) m_stored = code_of();
            m_q.delete();
            m_idle = 0;
            m_eval = 0;
            if (bus.Alarm) m_locked = 1;
        end else if (bus.Alarm) begin
            m_locked = 1;
            m_q.delete();
            m_idle = 0;
        end else if (bus.Clear) begin
            m_q.delete();
            m_idle = 0;
        end else begin
            took = bus.Key_Valid && (m_q.size() < DIGITS);
            if (took) begin
                m_q.push_back(int'(bus.Key_Data));
                m_idle = 0;
            end
            if (bus.Enter_Btn || bus.Change_Btn) begin
                m_eval    = 1;
                m_enter   = bus.Enter_Btn;
                m_change  = !bus.Enter_Btn && bus.Change_Btn;
                m_correct = !bus.New && (m_q.size() == DIGITS) && (code_of() == m_stored);
                m_load    = bus.New && (m_q.size() == DIGITS);
            end else if (!took && m_q.size() > 0) begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_q.delete();
                    m_idle = 0;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        #2;
        if (chk_en && Resetn) begin
            chk("enter_out",   int'(bus.Enter_Out),   int'(m_enter));
            chk("change_out",  int'(bus.Change_Out),  int'(m_change));
            chk("is_correct",  int'(bus.isCorrect),   int'(m_correct));
            chk("load_done",   int'(bus.Load_Done),   int'(m_load));
            chk("digit_count", int'(bus.Digit_Count), m_q.size());
            chk("key_ready",   int'(bus.Key_Ready),
                int'(!m_locked && !m_eval && (m_q.size() < DIGITS) && !bus.Alarm));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic idle_inputs();
        bus.Key_Valid = 0; bus.Key_Data = '0;
        bus.Enter_Btn = 0; bus.Change_Btn = 0;
        bus.Clear = 0; bus.New = 0; bus.Alarm = 0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        Resetn = 0;
        idle_inputs();
        @(negedge Clock);
        #1;
        chk("rst_enter_out",   int'(bus.Enter_Out),   0);
        chk("rst_is_correct",  int'(bus.isCorrect),   0);
        chk("rst_digit_count", int'(bus.Digit_Count), 0);
        chk("rst_key_ready",   int'(bus.Key_Ready),   1);
        Resetn = 1;
        model_reset();
        tick();
        chk_en = 1;
    endtask

    // Type the first n hex digits of code, one per cycle.
    task automatic key_in(input int n, input int code);
        for (int i = 0; i < n; i++) begin
            bus.Key_Valid = 1;
            bus.Key_Data  = 4'((code >> (4 * (n - 1 - i))) & 15);
            tick();
        end
        bus.Key_Valid = 0;
    endtask

    task automatic press(input bit e, input bit c);
        bus.Enter_Btn  = e;
        bus.Change_Btn = c;
        tick();
        bus.Enter_Btn  = 0;
        bus.Change_Btn = 0;
    endtask

    int idle_run;
    int r;
    int p;

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(negedge Clock);
        do_reset();

        // 1: correct code
        key_in(4, 'h1234);
        press(1, 0);
        chk("t1_enter", int'(bus.Enter_Out), 1);
        chk("t1_correct", int'(bus.isCorrect), 1);
        tick();
        chk("t1_enter_gone", int'(bus.Enter_Out), 0);
        chk("t1_count_clr", int'(bus.Digit_Count), 0);

        // 2: wrong code with Change, then partial code with Enter
        key_in(4, 'h1235);
        press(0, 1);
        chk("t2_change", int'(bus.Change_Out), 1);
        chk("t2_enter_low", int'(bus.Enter_Out), 0);
        chk("t2_wrong", int'(bus.isCorrect), 0);
        tick();
        key_in(3, 'h123);
        press(1, 0);
        chk("t2_partial", int'(bus.isCorrect), 0);
        tick();

        // 3: combination change
        bus.New = 1;
        key_in(4, 'h9876);
        press(1, 0);
        chk("t3_load", int'(bus.Load_Done), 1);
        chk("t3_enter", int'(bus.Enter_Out), 1);
        chk("t3_correct_low", int'(bus.isCorrect), 0);
        tick();
        bus.New = 0;
        key_in(4, 'h9876);
        press(1, 0);
        chk("t3_new_code_ok", int'(bus.isCorrect), 1);
        tick();
        key_in(4, 'h1234);
        press(1, 0);
        chk("t3_old_code_bad", int'(bus.isCorrect), 0);
        tick();

        // 4: handshake and timeout
        do_reset();
        key_in(4, 'h1234);
        bus.Key_Valid = 1; bus.Key_Data = 4'h5;
        #1;
        chk("t4_ready_full", int'(bus.Key_Ready), 0);
        tick();
        chk("t4_count_held", int'(bus.Digit_Count), 4);
        bus.Key_Valid = 0;
        bus.Clear = 1;
        tick();
        bus.Clear = 0;
        chk("t4_clear", int'(bus.Digit_Count), 0);
        key_in(2, 'h12);
        repeat (TIMEOUT - 1) tick();
        chk("t4_before_timeout", int'(bus.Digit_Count), 2);
        tick();
        chk("t4_timeout", int'(bus.Digit_Count), 0);
        key_in(4, 'h1234);
        press(1, 0);
        chk("t4_after_timeout", int'(bus.isCorrect), 1);
        tick();

        // 5: simultaneous events
        key_in(3, 'h123);
        bus.Key_Valid = 1; bus.Key_Data = 4'h4;
        press(1, 0);
        bus.Key_Valid = 0;
        chk("t5_digit_btn", int'(bus.isCorrect), 1);
        tick();
        key_in(4, 'h1234);
        bus.Clear = 1;
        press(1, 0);
        bus.Clear = 0;
        chk("t5_clear_btn_strobe", int'(bus.Enter_Out), 0);
        chk("t5_clear_btn_count", int'(bus.Digit_Count), 0);
        key_in(4, 'h1234);
        press(1, 1);
        chk("t5_both_enter", int'(bus.Enter_Out), 1);
        chk("t5_both_change", int'(bus.Change_Out), 0);
        tick();

        // 6: lockout and reset
        bus.Alarm = 1;
        #1;
        chk("t6_alarm_ready", int'(bus.Key_Ready), 0);
        tick();
        bus.Alarm = 0;
        #1;
        chk("t6_locked_ready", int'(bus.Key_Ready), 0);
        key_in(4, 'h1234);
        press(1, 0);
        chk("t6_locked_strobe", int'(bus.Enter_Out), 0);
        chk("t6_locked_count", int'(bus.Digit_Count), 0);
        do_reset();

        bus.New = 1;
        key_in(4, 'h5555);
        press(1, 0);
        bus.New = 0;
        chk("t6_eval_load", int'(bus.Load_Done), 1);
        chk_en = 0;
        #1 Resetn = 0;
        #1;
        chk("t6_rst_kills_strobe", int'(bus.Enter_Out), 0);
        chk("t6_rst_kills_load", int'(bus.Load_Done), 0);
        do_reset();
        key_in(4, 'h5555);
        press(1, 0);
        chk("t6_load_lost", int'(bus.isCorrect), 0);
        tick();
        key_in(4, 'h1234);
        press(1, 0);
        chk("t6_default_back", int'(bus.isCorrect), 1);
        tick();

        // randomized traffic
        idle_run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            if (idle_run > 0) begin
                bus.Key_Valid = 0;
                idle_run--;
            end else begin
                bus.Key_Valid = ($urandom % 2) == 1;
                if ($urandom % 50 == 0) idle_run = 6 + int'($urandom % 6);
            end
            p = m_q.size();
            if (($urandom % 4) != 0 && p < DIGITS)
                bus.Key_Data = 4'((m_stored >> (4 * (DIGITS - 1 - p))) & 15);
            else
                bus.Key_Data = 4'($urandom % 16);
            r = (p == DIGITS) ? int'($urandom % 5) : int'($urandom % 40);
            bus.Enter_Btn  = (r == 0) || (r == 2);
            bus.Change_Btn = (r == 1) || (r == 2);
            bus.Clear      = ($urandom % 64) == 0;
            if ($urandom % 40 == 0) bus.New = !bus.New;
            bus.Alarm = ($urandom % 2500) == 0;
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/combo_entry_controller.md
# combo_entry_controller

Keypad-side controller that sequences code entry for the combination lock FSM. It collects a fixed-length digit code over a valid/ready keypad handshake and compares it against the stored combination. It then presents `isCorrect` together with a single-cycle `Enter`/`Change` strobe to the lock FSM. It also owns the stored combination, reloading it while the lock FSM signals `New`.

## Interface

**Parameters**
- `DIGITS`, default 4: code length in digits.
- `DIGIT_W`, default 4: bits per digit.
- `DEFAULT_CODE`, default 16'h1234: combination after reset; width `DIGITS*DIGIT_W`.
- `TIMEOUT`, default 1000: idle cycles after the last accepted digit before the buffer is discarded. A value of 0 disables the timeout.

**Ports**
- `Clock`  in  1  system clock.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Key_Valid`  in  1  keypad digit valid.
- `Key_Data`  in  `DIGIT_W`  keypad digit.
- `Key_Ready`  out  1  controller accepts a digit this cycle.
- `Enter_Btn`  in  1  user Enter; single-cycle synchronous pulse.
- `Change_Btn`  in  1  user Change; single-cycle synchronous pulse.
- `Clear`  in  1  discard the partially entered code.
- `New`  in  1  from the lock FSM; it is in its change-combination state.
- `Alarm`  in  1  from the lock FSM; it is in lockout.
- `Enter_Out`  out  1  Enter strobe to the lock FSM.
- `Change_Out`  out  1  Change strobe to the lock FSM.
- `isCorrect`  out  1  compare result to the lock FSM.
- `Load_Done`  out  1  pulse: stored combination replaced.
- `Digit_Count`  out  clog2(`DIGITS`+1)  number of digits buffered.

## Operation

**States**
- `COLLECT`: accepts digits.
- `EVAL`: one cycle; issues the strobe.
- `LOCKED`: terminal state.

**Digit handshake**
- `Key_Ready` = (state == `COLLECT`) && (`Digit_Count` < `DIGITS`) && !`Alarm`.
- A digit is accepted when `Key_Valid` && `Key_Ready`.
- On acceptance: buffer <= {buffer[(`DIGITS`-1)*`DIGIT_W`-1:0], `Key_Data`}, so the first digit ends up in the MSB position. `Digit_Count` increments and the idle timer clears.
- When `Digit_Count` == `DIGITS`, `Key_Ready` = 0. Further digits are not accepted and are not lost; the keypad holds them.

**Button press in `COLLECT`**
- `Enter_Btn` or `Change_Btn` moves the FSM to `EVAL`.
- If both arrive in the same cycle, Enter takes priority.
- The selected button is latched for use in `EVAL`.

**`EVAL` (exactly one cycle)**
- The selected strobe (`Enter_Out` or `Change_Out`) is 1.
- `isCorrect` is 1 only if `New` was 0 at the button press, `Digit_Count` == `DIGITS`, and buffer == stored.
- If `New` was 1 at the button press and `Digit_Count` == `DIGITS`: stored <= buffer, `Load_Done` = 1, `isCorrect` = 0.
- If `New` was 1 with a partial code: no load; the old combination is retained. The strobe is still issued so the lock FSM returns to its initial state.
- The buffer and `Digit_Count` clear.
- The next state is `COLLECT`, or `LOCKED` if `Alarm` = 1.

**Clear and timeout**
- `Clear` in `COLLECT` clears the buffer and `Digit_Count` next cycle.
- Timeout applies when `TIMEOUT` > 0 and `Digit_Count` > 0: after `TIMEOUT` consecutive cycles with no accepted digit, the buffer and count clear.
- The timer is held at 0 while `Digit_Count` == 0.
- The timer is `clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.

**Lockout**
- `Alarm` = 1 in any state sends the FSM to `LOCKED` next cycle.
- `LOCKED` has all outputs 0 and `Key_Ready` 0; buttons and digits are ignored.
- Only `Resetn` exits `LOCKED`.

**Outputs**
- `Enter_Out`, `Change_Out`, `isCorrect` and `Load_Done` are registered and are 0 outside `EVAL`.

## Timing

**Reset** (asynchronous, immediate)
- State `COLLECT`; stored = `DEFAULT_CODE`; buffer = 0; `Digit_Count` = 0; timer = 0.
- `Enter_Out`, `Change_Out`, `isCorrect` and `Load_Done` are 0; `Key_Ready` is 1.
- Reset asserted mid-`EVAL` kills the strobe in the same cycle. A combination load not yet clocked is lost.

**Latency**
- A button sampled at edge t gives strobe and `isCorrect` high during cycle t+1 to t+2.
- The lock FSM samples them at edge t+2.
- Digits are accepted again from cycle t+2.

**Same-cycle events**
- Digit plus button: the digit is accepted and included in the evaluation. The 4th digit and Enter together evaluate a full code.
- `Clear` plus button: `Clear` wins; no strobe and the button is dropped.
- `Clear` plus digit: `Clear` wins; the digit is dropped, though `Key_Ready` was 1.
- Timeout expiry plus digit: the digit wins; it is accepted and the timer is reset.
- `Alarm` plus button: `LOCKED`; no strobe.
- Buttons arriving during `EVAL` or `LOCKED` are ignored.

## Test plan

Unless a scenario states otherwise, benches use `DIGITS`=4, `DIGIT_W`=4, `DEFAULT_CODE`=16'h1234 and `TIMEOUT`=8.

1. **Correct code:** Reset; digits 1,2,3,4; `Enter_Btn` at edge t -> during cycle t+1 `Enter_Out`=1 and `isCorrect`=1, both for exactly one cycle. `Digit_Count`=0 at t+2.
2. **Wrong code:** Digits 1,2,3,5, then `Change_Btn` -> one cycle of `Change_Out`=1 with `isCorrect`=0. Separately, digits 1,2,3 then Enter -> `isCorrect`=0.
3. **Combination change:** `New`=1; digits 9,8,7,6; Enter -> `Load_Done`=1 with `Enter_Out`=1 and `isCorrect`=0. Then with `New`=0: code 9876 + Enter -> `isCorrect`=1; code 1234 + Enter -> `isCorrect`=0.
4. **Handshake and timeout:**
   - A 5th digit with `Key_Valid` held high -> `Key_Ready`=0 and `Digit_Count` stays 4.
   - Digits 1,2 then 8 idle cycles -> `Digit_Count`=0.
   - Then 1,2,3,4 + Enter -> `isCorrect`=1.
5. **Simultaneous events:**
   - 4th digit and Enter in the same cycle -> `isCorrect`=1.
   - `Clear` with Enter -> no strobe and `Digit_Count`=0.
   - Enter with Change -> only `Enter_Out` pulses.
6. **Lockout and reset:**
   - `Alarm`=1 -> `Key_Ready`=0 next cycle and Enter produces no strobe until `Resetn`.
   - `Resetn` asserted during `EVAL` -> strobe drops immediately and stored = 16'h1234.
